// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// tone_sequencer : step table of (FCW, duration) pairs played out on sample strobes
// Rev 1.0
// ============================================================================
module tone_sequencer #(
  parameter int N_STEPS = 8,
  parameter int DUR_W   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [$clog2(N_STEPS)-1:0] i_wr_addr,
  input  logic [15:0]                i_wr_fcw,
  input  logic [DUR_W-1:0]           i_wr_dur,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic                       i_loop,
  input  logic                       i_sample_req,
  output logic [15:0]                o_fcw,
  output logic                       o_gate,
  output logic [$clog2(N_STEPS)-1:0] o_step,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_wr_err
);

  localparam int                ADDR_W    = $clog2(N_STEPS);
  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(N_STEPS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_fcw_tbl [N_STEPS];
  logic [DUR_W-1:0]  r_dur_tbl [N_STEPS];

  logic [15:0]       r_fcw,    w_fcw_nxt;
  logic [ADDR_W-1:0] r_step,   w_step_nxt;
  logic [DUR_W-1:0]  r_count,  w_count_nxt;
  logic              r_gate,   w_gate_nxt;
  logic              r_busy,   w_busy_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_wr_err, w_wr_err_nxt;

  logic [ADDR_W-1:0] w_next_step;
  logic              w_seq_end;
  logic              w_wr_accept;

  assign w_next_step = r_step + ADDR_W'(1);
  // The last table slot ends the sequence without looking past the table.
  assign w_seq_end   = (r_step == LAST_STEP) || (r_dur_tbl[w_next_step] == '0);
  assign w_wr_accept = i_wr_en && (r_state == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_STEPS; i++) begin
        r_fcw_tbl[i] <= '0;
        r_dur_tbl[i] <= '0;
      end
    end else if (w_wr_accept) begin
      r_fcw_tbl[i_wr_addr] <= i_wr_fcw;
      r_dur_tbl[i_wr_addr] <= i_wr_dur;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_fcw    <= '0;
      r_step   <= '0;
      r_count  <= '0;
      r_gate   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fcw    <= w_fcw_nxt;
      r_step   <= w_step_nxt;
      r_count  <= w_count_nxt;
      r_gate   <= w_gate_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_wr_err <= w_wr_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fcw_nxt    = r_fcw;
    w_step_nxt   = r_step;
    w_count_nxt  = r_count;
    w_gate_nxt   = r_gate;
    w_done_nxt   = 1'b0;
    w_wr_err_nxt = i_wr_en && (r_state == PLAY);

    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (r_dur_tbl[0] != '0) begin
            w_state_nxt = PLAY;
            w_step_nxt  = '0;
            w_fcw_nxt   = r_fcw_tbl[0];
            w_count_nxt = r_dur_tbl[0];
            w_gate_nxt  = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      PLAY: begin
        // Stop wins over any step or sequence end in the same cycle.
        if (i_stop) begin
          w_state_nxt = IDLE;
          w_step_nxt  = '0;
          w_count_nxt = '0;
          w_gate_nxt  = 1'b0;
        end else if (i_sample_req) begin
          if (r_count == DUR_W'(1)) begin
            if (!w_seq_end) begin
              w_step_nxt  = w_next_step;
              w_fcw_nxt   = r_fcw_tbl[w_next_step];
              w_count_nxt = r_dur_tbl[w_next_step];
            end else if (i_loop) begin
              w_step_nxt  = '0;
              w_fcw_nxt   = r_fcw_tbl[0];
              w_count_nxt = r_dur_tbl[0];
            end else begin
              w_state_nxt = IDLE;
              w_step_nxt  = '0;
              w_count_nxt = '0;
              w_gate_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_count_nxt = r_count - DUR_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == PLAY);
  end

  assign o_fcw    = r_fcw;
  assign o_gate   = r_gate;
  assign o_step   = r_step;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_wr_err = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
// tb_tone_sequencer : directed vector table plus reset corner sequences
// Rev 1.0
// ============================================================================
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_fcw = '0;
  logic [15:0] wr_dur = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        sreq = 1'b0;
  logic [15:0] fcw;
  logic        gate;
  logic [2:0]  step;
  logic        busy;
  logic        done;
  logic        wr_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wf;
    logic [15:0] wd;
    logic        st, sp, lp, sr;
    logic [22:0] exp;
  } vec_t;

  vec_t vq[$];

  tone_sequencer #(.N_STEPS(8), .DUR_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_fcw(wr_fcw), .i_wr_dur(wr_dur), .i_start(start), .i_stop(stop),
    .i_loop(loop_en), .i_sample_req(sreq), .o_fcw(fcw), .o_gate(gate),
    .o_step(step), .o_busy(busy), .o_done(done), .o_wr_err(wr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] pk(input logic [15:0] f, input logic g, input logic [2:0] s,
                                     input logic b, input logic d, input logic e);
    return {f, g, s, b, d, e};
  endfunction

  task automatic add(input logic we, input logic [2:0] wa, input logic [15:0] wf, input logic [15:0] wd,
                     input logic st, input logic sp, input logic lp, input logic sr, input logic [22:0] exp);
    vec_t v;
    v.we = we; v.wa = wa; v.wf = wf; v.wd = wd;
    v.st = st; v.sp = sp; v.lp = lp; v.sr = sr; v.exp = exp;
    vq.push_back(v);
  endtask

  // Idle table write; outputs stay idle with the given held FCW.
  task automatic wr(input logic [2:0] a, input logic [15:0] f, input logic [15:0] d, input logic [15:0] ef);
    add(1'b1, a, f, d, 1'b0, 1'b0, 1'b0, 1'b0, pk(ef, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic ctl(input logic st, input logic sp, input logic lp, input logic sr, input logic [22:0] exp);
    add(1'b0, 3'd0, 16'h0, 16'h0, st, sp, lp, sr, exp);
  endtask

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got fcw=%h gate=%b step=%0d busy=%b done=%b wr_err=%b, want fcw=%h gate=%b step=%0d busy=%b done=%b wr_err=%b",
               name, act[22:7], act[6], act[5:3], act[2], act[1], act[0],
               exp[22:7], exp[6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    // Three-step tone, one-shot: 3 strobes of 0x0100, 2 of 0x0200, then done.
    wr(3'd0, 16'h0100, 16'd3, 16'h0000);
    wr(3'd1, 16'h0200, 16'd2, 16'h0000);
    wr(3'd2, 16'h0300, 16'd0, 16'h0000);
    ctl(1, 0, 0, 0, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    ctl(0, 0, 0, 0, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0200, 1, 3'd1, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0200, 1, 3'd1, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0200, 0, 3'd0, 0, 1, 0));
    ctl(0, 0, 0, 1, pk(16'h0200, 0, 3'd0, 0, 0, 0));

    // Looping: two full passes, a start while playing is ignored, then stop.
    ctl(1, 0, 1, 0, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    for (int r = 0; r < 2; r++) begin
      ctl(0, 0, 1, 1, pk(16'h0100, 1, 3'd0, 1, 0, 0));
      ctl(1, 0, 1, 1, pk(16'h0100, 1, 3'd0, 1, 0, 0));
      ctl(0, 0, 1, 1, pk(16'h0200, 1, 3'd1, 1, 0, 0));
      ctl(0, 0, 1, 0, pk(16'h0200, 1, 3'd1, 1, 0, 0));
      ctl(0, 0, 1, 1, pk(16'h0200, 1, 3'd1, 1, 0, 0));
      ctl(0, 0, 1, 1, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    end
    ctl(0, 1, 0, 0, pk(16'h0100, 0, 3'd0, 0, 0, 0));

    // Write attempt while playing is rejected; step 1 replays as originally written.
    ctl(1, 0, 0, 0, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    add(1'b1, 3'd1, 16'hDEAD, 16'd7, 0, 0, 0, 0, pk(16'h0100, 1, 3'd0, 1, 0, 1));
    ctl(0, 0, 0, 1, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0200, 1, 3'd1, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0200, 1, 3'd1, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0200, 0, 3'd0, 0, 1, 0));

    // Stop coinciding with the final strobe: idle without done.
    ctl(1, 0, 0, 0, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0100, 1, 3'd0, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0200, 1, 3'd1, 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0200, 1, 3'd1, 1, 0, 0));
    ctl(0, 1, 0, 1, pk(16'h0200, 0, 3'd0, 0, 0, 0));
    ctl(0, 0, 0, 0, pk(16'h0200, 0, 3'd0, 0, 0, 0));

    // Full table, one strobe per step: ends on the last slot.
    for (int k = 0; k < 8; k++) wr(3'(k), 16'(k + 1), 16'd1, 16'h0200);
    ctl(1, 0, 0, 0, pk(16'h0001, 1, 3'd0, 1, 0, 0));
    for (int j = 1; j < 8; j++) ctl(0, 0, 0, 1, pk(16'(j + 1), 1, 3'(j), 1, 0, 0));
    ctl(0, 0, 0, 1, pk(16'h0008, 0, 3'd0, 0, 1, 0));
    ctl(0, 0, 0, 0, pk(16'h0008, 0, 3'd0, 0, 0, 0));

    #3 rst_n = 1'b0;
    #1 check("reset_state", {fcw, gate, step, busy, done, wr_err}, 23'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      wr_en = vq[i].we; wr_addr = vq[i].wa; wr_fcw = vq[i].wf; wr_dur = vq[i].wd;
      start = vq[i].st; stop = vq[i].sp; loop_en = vq[i].lp; sreq = vq[i].sr;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), {fcw, gate, step, busy, done, wr_err}, vq[i].exp);
    end

    // Asynchronous reset in the middle of playback, then restart with a cleared table.
    @(negedge clk);
    wr_en = 1'b0; stop = 1'b0; loop_en = 1'b0; sreq = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 check("pre_reset_play", {fcw, gate, step, busy, done, wr_err}, pk(16'h0001, 1, 3'd0, 1, 0, 0));
    @(negedge clk) start = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", {fcw, gate, step, busy, done, wr_err}, 23'd0);
    @(negedge clk);
    @(negedge clk) begin rst_n = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1 check("empty_start_done", {fcw, gate, step, busy, done, wr_err}, pk(16'h0000, 0, 3'd0, 0, 1, 0));
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    #1 check("empty_start_idle", {fcw, gate, step, busy, done, wr_err}, 23'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
